// File: rtl/bank_arb_pkg.sv
// ---------------------------------------------------------------------------
// bank_arb_pkg
// Shared definitions for the per-bank request queues that feed the bank-group
// drain arbiter.
//   req_t          : default-width request word
//   DEPTH_DEF      : default FIFO depth
//   MAX_BURST_DEF  : default cap on consecutive pops before a holdoff cycle
//   burst_state_e  : burst limiter states (RUN, HOLD)
// ---------------------------------------------------------------------------
package bank_arb_pkg;

  localparam int unsigned REQ_W_DEF     = 32;
  localparam int unsigned DEPTH_DEF     = 8;
  localparam int unsigned MAX_BURST_DEF = 4;

  typedef logic [REQ_W_DEF-1:0] req_t;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } burst_state_e;

endpackage

// File: rtl/req_fifo_storage.sv
// ---------------------------------------------------------------------------
// req_fifo_storage
// Register-array storage for bank_req_queue: synchronous write, asynchronous
// read. Holds no pointers or occupancy state; the owner manages those.
// Ports:
//   clk      in   rising-edge clock
//   wr_en    in   write wr_data into entry wr_addr this cycle
//   wr_addr  in   write index
//   wr_data  in   word to store
//   rd_addr  in   read index
//   rd_data  out  combinational read of entry rd_addr
// Storage is deliberately not reset; occupancy tracking makes stale entries
// invisible.
// ---------------------------------------------------------------------------
module req_fifo_storage
  import bank_arb_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned REQ_W = REQ_W_DEF
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [REQ_W-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [REQ_W-1:0]         rd_data
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [REQ_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] row_we;

  // One-hot write-enable decode, one bit per entry.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_row_we
    assign row_we[gi] = wr_en && (wr_addr == AW'(gi));
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (row_we[i]) begin
        mem_q[i] <= wr_data;
      end
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/bank_req_queue.sv
// ---------------------------------------------------------------------------
// bank_req_queue
// Per-bank request FIFO presented to the bank-group drain arbiter as a
// valid/ready responder. One instance per bank.
// Ports:
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset (flushes entries)
//   push_valid  in   producer offers push_data
//   push_data   in   request word
//   push_ready  out  queue can accept (count < DEPTH), registered-state only
//   valid       out  head entry offered to the arbiter, registered-state only
//   ready       in   arbiter drains the head this cycle
//   pop_data    out  head entry (asynchronous read), meaningful while valid
//   count       out  current occupancy
//   burst_hold  out  holdoff cycle active (burst-cap build only)
// Build option:
//   BANK_REQ_QUEUE_BURST_CAP_EN - when defined, after MAX_BURST back-to-back
//   pops valid drops for exactly one cycle so the arbiter rotates to another
//   bank. When undefined the queue drains until empty and MAX_BURST is unused.
// ---------------------------------------------------------------------------
module bank_req_queue
  import bank_arb_pkg::*;
#(
  parameter int unsigned DEPTH     = DEPTH_DEF,
  parameter int unsigned REQ_W     = REQ_W_DEF,
  parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_valid,
  input  logic [REQ_W-1:0]       push_data,
  output logic                   push_ready,
  output logic                   valid,
  input  logic                   ready,
  output logic [REQ_W-1:0]       pop_data,
  output logic [$clog2(DEPTH):0] count
`ifdef BANK_REQ_QUEUE_BURST_CAP_EN
  ,
  output logic                   burst_hold
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          not_empty;
  logic          push_fire;
  logic          pop_fire;

  // Occupancy, handshakes and pointer/count updates. push_ready and valid are
  // derived only from registers because the arbiter forms ready from valid.
  always_comb begin
    not_empty  = (count_q != '0);
    push_ready = (count_q != CW'(DEPTH));
    push_fire  = push_valid && push_ready;
    pop_fire   = valid && ready;

    // DEPTH is a power of two, so the natural wrap of an AW-bit pointer is
    // the modulo-DEPTH increment.
    wr_ptr_d = push_fire ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_fire  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    count_d = count_q;
    case ({push_fire, pop_fire})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;

`ifdef BANK_REQ_QUEUE_BURST_CAP_EN
  // Counter must hold values up to MAX_BURST-1; keep at least one bit.
  localparam int unsigned BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  burst_state_e  state_q, state_d;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;

  // burst_cnt counts back-to-back pops; any idle cycle restarts the run, so
  // the holdoff only triggers on MAX_BURST truly consecutive pops.
  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    valid       = 1'b0;
    burst_hold  = 1'b0;
    case (state_q)
      RUN: begin
        valid = not_empty;
        if (not_empty && ready) begin
          if (burst_cnt_q == BW'(MAX_BURST - 1)) begin
            burst_cnt_d = '0;
            state_d     = HOLD;
          end else begin
            burst_cnt_d = burst_cnt_q + BW'(1);
          end
        end else begin
          burst_cnt_d = '0;
        end
      end
      HOLD: begin
        // Single dead cycle so the arbiter sees this bank drop and rotates.
        burst_hold  = 1'b1;
        burst_cnt_d = '0;
        state_d     = RUN;
      end
      default: begin
        burst_cnt_d = '0;
        state_d     = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end
`else
  assign valid = not_empty;
`endif

  req_fifo_storage #(
    .DEPTH (DEPTH),
    .REQ_W (REQ_W)
  ) u_storage (
    .clk     (clk),
    .wr_en   (push_fire),
    .wr_addr (wr_ptr_q),
    .wr_data (push_data),
    .rd_addr (rd_ptr_q),
    .rd_data (pop_data)
  );

endmodule

// File: tb/tb_bank_req_queue.sv
// ---------------------------------------------------------------------------
// tb_bank_req_queue
// Directed bench for bank_req_queue (DEPTH=8, REQ_W=32, MAX_BURST=4).
// Expected values are hand-derived; build with BANK_REQ_QUEUE_BURST_CAP_EN
// defined to exercise the burst-cap variant.
// ---------------------------------------------------------------------------
module tb_bank_req_queue;
  import bank_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        push_valid;
  req_t        push_data;
  logic        push_ready;
  logic        valid;
  logic        ready;
  req_t        pop_data;
  logic [3:0]  count;
`ifdef BANK_REQ_QUEUE_BURST_CAP_EN
  logic        burst_hold;
`endif

  int n_total = 0;
  int n_bad   = 0;

  bank_req_queue #(
    .DEPTH     (8),
    .REQ_W     (32),
    .MAX_BURST (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .push_valid (push_valid),
    .push_data  (push_data),
    .push_ready (push_ready),
    .valid      (valid),
    .ready      (ready),
    .pop_data   (pop_data),
    .count      (count)
`ifdef BANK_REQ_QUEUE_BURST_CAP_EN
    ,
    .burst_hold (burst_hold)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input req_t d);
    push_valid = 1'b1;
    push_data  = d;
    step();
    push_valid = 1'b0;
    $display("push data=%h count=%0d push_ready=%0b", d, count, push_ready);
  endtask

  logic       exp_v [9];
  logic [7:0] exp_d [9];
  logic       exp_h [9];
  int         rd_idx;

  initial begin
    rst        = 1'b1;
    push_valid = 1'b0;
    push_data  = '0;
    ready      = 1'b1;
    step();
    step();

    // ---- reset state ----
    check_eq("rst_count", count, 0);
    check_eq("rst_valid", valid, 0);
    check_eq("rst_push_ready", push_ready, 1);
`ifdef BANK_REQ_QUEUE_BURST_CAP_EN
    check_eq("rst_burst_hold", burst_hold, 0);
`endif
    rst = 1'b0;

    // ---- idle with ready high: nothing changes ----
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq("idle_count", count, 0);
      check_eq("idle_valid", valid, 0);
      check_eq("idle_push_ready", push_ready, 1);
    end

    // ---- fill to full ----
    ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      push_word(32'hA0 + i);
      check_eq("fill_count", count, i + 1);
      check_eq("fill_valid", valid, 1);
    end
    check_eq("full_push_ready", push_ready, 0);
    push_word(32'hFF);
    check_eq("full_reject_count", count, 8);
    check_eq("full_head", pop_data, 32'hA0);

    // push while full with a simultaneous pop: pop happens, push rejected
    push_valid = 1'b1;
    push_data  = 32'hEE;
    ready      = 1'b1;
    step();
    push_valid = 1'b0;
    ready      = 1'b0;
    $display("pop+push at full count=%0d head=%h", count, pop_data);
    check_eq("full_pop_count", count, 7);
    check_eq("full_pop_head", pop_data, 32'hA1);
    check_eq("full_pop_push_ready", push_ready, 1);

    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("flush_count", count, 0);
    check_eq("flush_valid", valid, 0);

    // ---- burst drain of 6 entries with ready held high ----
    for (int i = 0; i < 6; i++) push_word(32'hA0 + i);
`ifdef BANK_REQ_QUEUE_BURST_CAP_EN
    exp_v = '{1, 1, 1, 1, 0, 1, 1, 0, 0};
    exp_d = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'h00, 8'hA4, 8'hA5, 8'h00, 8'h00};
    exp_h = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
`else
    exp_v = '{1, 1, 1, 1, 1, 1, 0, 0, 0};
    exp_d = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'h00, 8'h00, 8'h00};
    exp_h = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
`endif
    ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      $display("drain cycle=%0d valid=%0b data=%h count=%0d", c, valid, pop_data, count);
      check_eq("burst_valid", valid, exp_v[c]);
      if (exp_v[c]) check_eq("burst_data", pop_data, 32'(exp_d[c]));
`ifdef BANK_REQ_QUEUE_BURST_CAP_EN
      check_eq("burst_hold", burst_hold, exp_h[c]);
`endif
      step();
    end
    check_eq("burst_end_count", count, 0);

    // ---- simultaneous push/pop at count 3, order across pointer wrap ----
    ready = 1'b0;
    for (int i = 0; i < 3; i++) push_word(32'hB0 + i);
    check_eq("pp_start_count", count, 3);
    ready  = 1'b1;
    rd_idx = 0;
    for (int i = 3; i < 20; i++) begin
      push_valid = 1'b1;
      push_data  = 32'hB0 + i;
      if (valid) begin
        check_eq("pp_order", pop_data, 32'hB0 + rd_idx);
        rd_idx++;
      end
      step();
      $display("push+pop push=%h count=%0d", 32'hB0 + i, count);
`ifdef BANK_REQ_QUEUE_BURST_CAP_EN
      if (i < 7) check_eq("pp_count", count, 3);
`else
      check_eq("pp_count", count, 3);
`endif
    end
    push_valid = 1'b0;
    for (int c = 0; c < 40 && rd_idx < 20; c++) begin
      if (valid) begin
        $display("pop data=%h", pop_data);
        check_eq("pp_drain_order", pop_data, 32'hB0 + rd_idx);
        rd_idx++;
      end
      step();
    end
    check_eq("pp_words_seen", rd_idx, 20);
    check_eq("pp_end_count", count, 0);

    // ---- reset during holdoff with count 5 ----
    ready = 1'b0;
    for (int i = 0; i < 5; i++) push_word(32'hE0 + i);
    ready = 1'b1;
    for (int i = 5; i < 9; i++) begin
      push_valid = 1'b1;
      push_data  = 32'hE0 + i;
      step();
    end
    push_valid = 1'b0;
    ready      = 1'b0;
    check_eq("pre_rst_count", count, 5);
`ifdef BANK_REQ_QUEUE_BURST_CAP_EN
    check_eq("pre_rst_hold", burst_hold, 1);
    check_eq("pre_rst_valid", valid, 0);
`endif
    rst = 1'b1;
    step();
    rst = 1'b0;
    $display("reset mid-op count=%0d valid=%0b", count, valid);
    check_eq("mid_rst_count", count, 0);
    check_eq("mid_rst_valid", valid, 0);
    check_eq("mid_rst_push_ready", push_ready, 1);
`ifdef BANK_REQ_QUEUE_BURST_CAP_EN
    check_eq("mid_rst_hold", burst_hold, 0);
`endif
    push_word(32'hD0);
    check_eq("post_rst_valid", valid, 1);
    check_eq("post_rst_data", pop_data, 32'hD0);
    check_eq("post_rst_count", count, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/bank_req_queue.md
# bank_req_queue

Per-bank request buffer feeding the bank-group drain arbiter. Accepts scheduled requests on a push interface, stores them in a FIFO, and presents them to the arbiter as a `valid`/`ready` responder. Optionally caps consecutive pops so the arbiter rotates to other banks. One instance per bank; four instances drive the arbiter's 4-bit `Valid` bus and receive its per-bank `Ready_*` outputs.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `REQ_W`, 32: request word width.
- `MAX_BURST`, 4: consecutive pops before forced holdoff; ≥1.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `push_valid`  in  1  producer offers `push_data`.
- `push_data`  in  REQ_W  request word.
- `push_ready`  out  1  queue can accept; high iff `count < DEPTH`.
- `valid`  out  1  head entry available to arbiter.
- `ready`  in  1  arbiter drains head this cycle.
- `pop_data`  out  REQ_W  head entry; meaningful only while `valid`.
- `count`  out  $clog2(DEPTH)+1  current occupancy.
- `burst_hold`  out  1  holdoff active; only exists in the burst-cap build.

## Operation
- Push accepted when `push_valid && push_ready`; written at `wr_ptr`, which increments modulo DEPTH.
- Pop occurs when `valid && ready`; `rd_ptr` increments modulo DEPTH.
- `count` update: +1 on push only, −1 on pop only, unchanged on both or neither.
- `push_ready` and `valid` are functions of registered state only. Neither depends combinationally on `ready` or `push_valid`, because the arbiter derives `ready` combinationally from `valid`.
- `pop_data` is an asynchronous read of storage at `rd_ptr`.
- Burst FSM, 2 states:
  - `RUN`: `valid = (count != 0)`. `burst_cnt` increments on each pop and clears on any cycle with no pop. A pop with `burst_cnt == MAX_BURST-1` clears `burst_cnt` and moves to `HOLD`.
  - `HOLD`: `valid = 0`; pushes still accepted. Returns to `RUN` after exactly one cycle.
- The `HOLD` cycle makes the arbiter see the bank drop, so it asserts `done` and moves to the next valid bank.

Boundaries:
- Full: `push_ready = 0`; a push attempted with a simultaneous pop is still rejected, since `push_ready` is registered-state based.
- Empty: no fall-through; a push into an empty queue gives `valid` on the next cycle.
- Push and pop in the same cycle with `0 < count < DEPTH`: both occur and `count` is unchanged.
- `ready` while `valid = 0`: ignored; no state change.
- Pointer wrap: `DEPTH-1 → 0` on both sides. Full/empty are determined by `count`, not pointer compare.

## Timing
- Reset values: `count = 0`, `push_ready = 1`, `valid = 0`, `burst_hold = 0`, pointers 0, FSM `RUN`, `burst_cnt = 0`. `pop_data` is don't-care.
- Reset mid-operation flushes all entries on the next edge; storage contents are not cleared.
- Push → `valid` latency: 1 cycle.
- Pop → `count` and `pop_data` update: next cycle.
- Holdoff: exactly 1 cycle of `valid = 0` after every MAX_BURST back-to-back pops, even if entries remain.

## Configuration
- Macro `BANK_REQ_QUEUE_BURST_CAP_EN`.
- Defined: burst FSM, `burst_cnt` and the `burst_hold` port are present, and `MAX_BURST` is honoured.
- Undefined: no FSM and no `burst_hold` port; `valid = (count != 0)` always, so the arbiter drains the queue until empty; `MAX_BURST` is unused.

## Structure
- Shared package `bank_arb_pkg` holds `req_t` (REQ_W-wide request typedef), the default `DEPTH`/`MAX_BURST` constants, and the burst FSM state enum (`RUN`, `HOLD`).
- Natural sub-module: `req_fifo_storage`, a register array with synchronous write and asynchronous read, parameterised by DEPTH and REQ_W. Pointers, `count` and the FSM stay in `bank_req_queue`.

## Test plan
- Reset then idle: `count = 0`, `valid = 0`, `push_ready = 1` for 10 cycles; `ready = 1` throughout with no state change.
- Push 0xA0..0xA7 (DEPTH = 8) back-to-back → `push_ready = 0` after the 8th, `count = 8`; a 9th push is rejected and `count` stays 8.
- Cap enabled, MAX_BURST = 4, 6 entries, `ready` held high → pops 0xA0..0xA3 on 4 consecutive cycles, then one cycle `valid = 0` / `burst_hold = 1`, then pops 0xA4, 0xA5, then `valid = 0` when empty.
- Cap disabled, same stimulus → 6 consecutive pops with no gap.
- Simultaneous push and pop at `count = 3` → `count` stays 3 and FIFO order is preserved across the pointer wrap (fill/drain 20 words, check sequence).
- Assert `rst` with `count = 5` during `HOLD` → next cycle `count = 0`, `valid = 0`, FSM `RUN`; a fresh push gives `valid` one cycle later.
